// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the memory-address sequencer.
// Holds the exception-vector FSM state encoding and the named exception codes.
package cpu_mem_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    VEC_ADDR = 3'd1,
    WAIT     = 3'd2,
    CAPTURE  = 3'd3,
    DONE     = 3'd4
  } seq_state_e;

  localparam int unsigned VEC_BASE_DEFAULT = 253;

  localparam int unsigned EXC_OPCODE   = 0;
  localparam int unsigned EXC_OVERFLOW = 1;
  localparam int unsigned EXC_DIV0     = 2;

  // Word accesses must land on a 4-byte boundary.
  function automatic logic is_misaligned(input logic word_access, input logic [1:0] addr_lsb);
    return word_access && (addr_lsb != 2'b00);
  endfunction

endpackage

// File: rtl/addr_src_mux.sv
// Combinational N_SRC:1 address-source selector.
// Passes hold_val through and raises sel_invalid when sel names no source.
module addr_src_mux #(
  parameter int DATA_W = 32,
  parameter int N_SRC  = 3,
  parameter int SEL_W  = 2
) (
  input  logic [SEL_W-1:0]        sel,
  input  logic [N_SRC*DATA_W-1:0] in_src,
  input  logic [DATA_W-1:0]       hold_val,
  output logic [DATA_W-1:0]       mux_out,
  output logic                    sel_invalid
);

  always_comb begin
    mux_out     = hold_val;
    sel_invalid = 1'b1;
    for (int i = 0; i < N_SRC; i++) begin
      if (sel == SEL_W'(i)) begin
        mux_out     = in_src[i*DATA_W +: DATA_W];
        sel_invalid = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mem_addr_sequencer.sv
// Registered memory-address source with an exception-vector fetch sequence.
// Drives the vector address, waits MEM_LAT cycles, captures the handler byte.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | normal addressing; accepts exc_req or addr_en
// VEC_ADDR | vector-table address on addr_out; load wait counter
// WAIT     | count down memory read latency
// CAPTURE  | latch mem_data_in[7:0] into handler_addr
// DONE     | exc_done pulse, back to IDLE
module mem_addr_sequencer
  import cpu_mem_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int N_SRC    = 3,
  parameter int SEL_W    = 2,
  parameter int N_VEC    = 3,
  parameter int VEC_W    = 2,
  parameter int VEC_BASE = VEC_BASE_DEFAULT,
  parameter int MEM_LAT  = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    addr_en,
  input  logic                    word_access,
  input  logic [N_SRC*DATA_W-1:0] in_src,
  input  logic                    exc_req,
  input  logic [VEC_W-1:0]        exc_code,
  input  logic [DATA_W-1:0]       mem_data_in,
  output logic [DATA_W-1:0]       addr_out,
  output logic                    busy,
  output logic                    exc_done,
  output logic [DATA_W-1:0]       handler_addr,
  output logic                    exc_bad,
  output logic                    misaligned
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [VEC_W:0] N_VEC_V = (VEC_W+1)'(N_VEC);

  seq_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] handler_q, handler_d;
  logic              bad_q, bad_d;
  logic              mis_q, mis_d;

  logic [DATA_W-1:0] src_val;
  logic              src_invalid;
  logic              code_ok;
  logic [VEC_W-1:0]  vec_idx;
  logic              unused_mem_hi;

  addr_src_mux #(
    .DATA_W (DATA_W),
    .N_SRC  (N_SRC),
    .SEL_W  (SEL_W)
  ) u_src_mux (
    .sel         (sel),
    .in_src      (in_src),
    .hold_val    (addr_q),
    .mux_out     (src_val),
    .sel_invalid (src_invalid)
  );

  // Only the low byte of memory data is a handler address.
  assign unused_mem_hi = ^mem_data_in[DATA_W-1:8];

  assign code_ok = ({1'b0, exc_code} < N_VEC_V);
  assign vec_idx = code_ok ? exc_code : '0;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    handler_d = handler_q;
    bad_d     = bad_q;

    case (state_q)
      IDLE: begin
        if (exc_req) begin
          bad_d   = !code_ok;
          addr_d  = DATA_W'(VEC_BASE) + DATA_W'(vec_idx);
          state_d = VEC_ADDR;
        end else if (addr_en && !src_invalid) begin
          addr_d = src_val;
        end
      end
      VEC_ADDR: begin
        cnt_d   = CNT_W'(MEM_LAT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      CAPTURE: begin
        handler_d = {{(DATA_W-8){1'b0}}, mem_data_in[7:0]};
        state_d   = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Vector addresses go through the same alignment check as normal loads.
    mis_d = is_misaligned(word_access, addr_d[1:0]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      handler_q <= '0;
      bad_q     <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      handler_q <= handler_d;
      bad_q     <= bad_d;
      mis_q     <= mis_d;
    end
  end

  assign addr_out     = addr_q;
  assign handler_addr = handler_q;
  assign exc_bad      = bad_q;
  assign misaligned   = mis_q;
  assign busy         = (state_q != IDLE);
  assign exc_done     = (state_q == DONE);

endmodule

// File: tb/tb_mem_addr_sequencer.sv
// Bench for mem_addr_sequencer: two instances (MEM_LAT=1 and 3) share stimulus
// and are checked every cycle against a cycle-offset reference model.
module tb_mem_addr_sequencer;

  logic        clk;
  logic        reset;
  logic [1:0]  sel;
  logic        addr_en;
  logic        word_access;
  logic [95:0] in_src;
  logic        exc_req;
  logic [1:0]  exc_code;
  logic [31:0] mem_data_in;

  logic [31:0] addr_o [2];
  logic [31:0] hand_o [2];
  logic        busy_o [2];
  logic        done_o [2];
  logic        bad_o  [2];
  logic        mis_o  [2];

  int n_total = 0;
  int n_bad   = 0;

  typedef struct {
    bit          active;
    int          r;
    int          lat;
    logic [31:0] addr;
    logic [31:0] handler;
    bit          bad;
    bit          mis;
  } mdl_t;

  mdl_t m [2];

  mem_addr_sequencer #(.MEM_LAT(1)) dut1 (
    .clk (clk), .reset (reset), .sel (sel), .addr_en (addr_en),
    .word_access (word_access), .in_src (in_src), .exc_req (exc_req),
    .exc_code (exc_code), .mem_data_in (mem_data_in),
    .addr_out (addr_o[0]), .busy (busy_o[0]), .exc_done (done_o[0]),
    .handler_addr (hand_o[0]), .exc_bad (bad_o[0]), .misaligned (mis_o[0])
  );

  mem_addr_sequencer #(.MEM_LAT(3)) dut3 (
    .clk (clk), .reset (reset), .sel (sel), .addr_en (addr_en),
    .word_access (word_access), .in_src (in_src), .exc_req (exc_req),
    .exc_code (exc_code), .mem_data_in (mem_data_in),
    .addr_out (addr_o[1]), .busy (busy_o[1]), .exc_done (done_o[1]),
    .handler_addr (hand_o[1]), .exc_bad (bad_o[1]), .misaligned (mis_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Sequence position r counts edges since acceptance: DONE is at r = 2+lat,
  // the handler byte is captured on the edge that enters DONE.
  function automatic mdl_t step(input mdl_t s);
    mdl_t n = s;
    if (reset) begin
      n.active = 0; n.r = 0; n.addr = '0; n.handler = '0; n.bad = 0; n.mis = 0;
      return n;
    end
    if (!s.active) begin
      if (exc_req) begin
        n.active = 1;
        n.r      = 0;
        n.bad    = (exc_code >= 3);
        n.addr   = 253 + (n.bad ? 0 : int'(exc_code));
      end else if (addr_en && sel < 3) begin
        n.addr = in_src[sel*32 +: 32];
      end
    end else if (s.r == 2 + s.lat) begin
      n.active = 0;
    end else begin
      n.r = s.r + 1;
      if (n.r == 2 + s.lat) n.handler = {24'h0, mem_data_in[7:0]};
    end
    n.mis = word_access && (n.addr[1:0] != 2'b00);
    return n;
  endfunction

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("addr_out[%0d]", i), addr_o[i], m[i].addr);
      chk($sformatf("handler[%0d]", i), hand_o[i], m[i].handler);
      chk($sformatf("busy[%0d]", i), 32'(busy_o[i]), 32'(m[i].active));
      chk($sformatf("exc_done[%0d]", i), 32'(done_o[i]),
          32'(m[i].active && m[i].r == 2 + m[i].lat));
      chk($sformatf("exc_bad[%0d]", i), 32'(bad_o[i]), 32'(m[i].bad));
      chk($sformatf("misaligned[%0d]", i), 32'(mis_o[i]), 32'(m[i].mis));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 2; i++) m[i] = step(m[i]);
    @(negedge clk);
    check_all();
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    int done_at [2];
    int busy_cnt [2];
    int done_cnt [2];

    m[0] = '{active: 0, r: 0, lat: 1, addr: '0, handler: '0, bad: 0, mis: 0};
    m[1] = '{active: 0, r: 0, lat: 3, addr: '0, handler: '0, bad: 0, mis: 0};
    reset = 1'b1; sel = '0; addr_en = 1'b0; word_access = 1'b0;
    in_src = {32'h300, 32'h200, 32'h100};
    exc_req = 1'b0; exc_code = '0; mem_data_in = 32'h0000_00A7;
    drain(2);
    chk("reset_addr", addr_o[0], 32'h0);
    reset = 1'b0;

    // normal selection
    sel = 2'd1; addr_en = 1'b1; tick();
    chk("sel1_load", addr_o[0], 32'h200);
    sel = 2'd3; tick();
    chk("sel3_hold", addr_o[0], 32'h200);
    sel = 2'd2; addr_en = 1'b0; tick();
    chk("en0_hold", addr_o[0], 32'h200);

    // exception path, code 1
    exc_req = 1'b1; exc_code = 2'd1; tick();
    exc_req = 1'b0;
    chk("vec_addr_254", addr_o[0], 32'd254);
    done_at = '{-1, -1}; busy_cnt = '{0, 0};
    for (int i = 0; i < 2; i++) if (busy_o[i]) busy_cnt[i]++;
    for (int k = 1; k <= 10; k++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        if (busy_o[i]) busy_cnt[i]++;
        if (done_o[i] && done_at[i] < 0) done_at[i] = k;
      end
    end
    chk("lat1_done_at", 32'(done_at[0]), 32'd3);
    chk("lat3_done_at", 32'(done_at[1]), 32'd5);
    chk("lat1_busy_cycles", 32'(busy_cnt[0]), 32'd4);
    chk("lat3_busy_cycles", 32'(busy_cnt[1]), 32'd6);
    chk("handler_a7", hand_o[0], 32'hA7);

    // bad code then good code
    exc_req = 1'b1; exc_code = 2'd3; tick();
    exc_req = 1'b0;
    chk("bad_flag", 32'(bad_o[0]), 32'd1);
    chk("bad_addr", addr_o[0], 32'd253);
    drain(8);
    exc_req = 1'b1; exc_code = 2'd2; tick();
    exc_req = 1'b0;
    chk("good_flag", 32'(bad_o[0]), 32'd0);
    chk("good_addr", addr_o[0], 32'd255);
    drain(8);

    // priority and ignore
    exc_req = 1'b1; exc_code = 2'd0; addr_en = 1'b1; sel = 2'd0; tick();
    exc_req = 1'b0; addr_en = 1'b0;
    chk("prio_addr", addr_o[0], 32'd253);
    tick();
    exc_req = 1'b1; exc_code = 2'd1; addr_en = 1'b1; tick();
    exc_req = 1'b0; addr_en = 1'b0;
    done_cnt = '{0, 0};
    for (int k = 0; k < 10; k++) begin
      tick();
      for (int i = 0; i < 2; i++) if (done_o[i]) done_cnt[i]++;
    end
    chk("one_done_lat1", 32'(done_cnt[0]), 32'd1);
    chk("one_done_lat3", 32'(done_cnt[1]), 32'd1);
    chk("ignored_addr", addr_o[1], 32'd253);

    // async reset during WAIT of the MEM_LAT=3 instance
    mem_data_in = 32'h0000_005C;
    exc_req = 1'b1; exc_code = 2'd2; tick();
    exc_req = 1'b0;
    drain(2);
    chk("in_wait_busy", 32'(busy_o[1]), 32'd1);
    reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) m[i] = step(m[i]);
    check_all();
    chk("rst_imm_addr", addr_o[1], 32'h0);
    chk("rst_imm_busy", 32'(busy_o[1]), 32'd0);
    @(negedge clk);
    drain(2);
    reset = 1'b0;
    done_cnt = '{0, 0};
    for (int k = 0; k < 8; k++) begin
      tick();
      for (int i = 0; i < 2; i++) if (done_o[i]) done_cnt[i]++;
    end
    chk("no_done_after_rst", 32'(done_cnt[1]), 32'd0);

    // alignment
    word_access = 1'b1; sel = 2'd0; addr_en = 1'b1;
    in_src[31:0] = 32'h102; tick();
    chk("mis_102", 32'(mis_o[0]), 32'd1);
    in_src[31:0] = 32'h104; tick();
    chk("mis_104", 32'(mis_o[0]), 32'd0);
    word_access = 1'b0; in_src[31:0] = 32'h103; tick();
    chk("mis_103_byte", 32'(mis_o[0]), 32'd0);
    addr_en = 1'b0;

    // randomized phase
    for (int k = 0; k < 3000; k++) begin
      reset       = ($urandom_range(0, 299) == 0);
      sel         = 2'($urandom_range(0, 3));
      addr_en     = 1'($urandom);
      word_access = 1'($urandom);
      in_src      = {$urandom, $urandom, $urandom};
      exc_req     = ($urandom_range(0, 7) == 0);
      exc_code    = 2'($urandom_range(0, 3));
      mem_data_in = $urandom;
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_addr_sequencer.md
Name: mem_addr_sequencer

Overview:
- Registered, parametrised successor to the memory-address source mux of the multicycle CPU.
- Selects the memory address from N_SRC packed sources, for example regA, PC and ALUout.
- Contains an exception-vector FSM. On an exception request it:
  - drives the vector-table address,
  - waits the memory read latency,
  - captures the handler byte,
  - returns a zero-extended handler address to the control unit.
- Sits between the control unit, the address-source registers and the memory address port.

Parameters:
- DATA_W, 32: address and data width.
- N_SRC, 3: number of normal address sources.
- SEL_W, 2: select width; must satisfy 2**SEL_W >= N_SRC.
- N_VEC, 3: number of exception vectors.
- VEC_W, 2: exception-code width.
- VEC_BASE, 253: address of vector 0; vector k is at VEC_BASE+k.
- MEM_LAT, 1: memory read latency in cycles, >= 1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- sel  in  SEL_W  normal address-source select.
- addr_en  in  1  load the selected source into addr_out.
- word_access  in  1  current access is a word access; enables the alignment check.
- in_src  in  N_SRC*DATA_W  packed sources; source i occupies bits [i*DATA_W +: DATA_W].
- exc_req  in  1  exception request, one-cycle pulse.
- exc_code  in  VEC_W  exception cause index.
- mem_data_in  in  DATA_W  memory read data; only [7:0] is used.
- addr_out  out  DATA_W  registered memory address.
- busy  out  1  FSM is not in IDLE.
- exc_done  out  1  one-cycle pulse; handler_addr is valid.
- handler_addr  out  DATA_W  zero-extended handler byte; held until the next capture.
- exc_bad  out  1  registered; exc_code was >= N_VEC on the last accepted request.
- misaligned  out  1  registered; word_access and addr_out[1:0] != 0.

Behaviour:
- Reset (asynchronous, immediate): addr_out=0, handler_addr=0, state=IDLE, wait counter=0, busy=0, exc_done=0, exc_bad=0, misaligned=0.
- Reset mid-sequence aborts the sequence; no exc_done pulse is produced.
- States: IDLE, VEC_ADDR, WAIT, CAPTURE, DONE.
- IDLE:
  - If exc_req=1, go to VEC_ADDR. exc_req takes priority over addr_en in the same cycle.
  - Otherwise, if addr_en=1, load addr_out with source sel on the next edge.
  - sel >= N_SRC: addr_out holds its value and no error is flagged.
  - addr_en=0: addr_out holds.
- Request acceptance:
  - On acceptance, latch idx = exc_code, or 0 if exc_code >= N_VEC.
  - Set exc_bad = (exc_code >= N_VEC).
- VEC_ADDR: addr_out = VEC_BASE + idx, computed in DATA_W with no wrap check. Load the counter with MEM_LAT-1, then go to WAIT.
- WAIT: decrement the counter; go to CAPTURE when the counter reads 0. With MEM_LAT=1, WAIT lasts exactly one cycle.
- CAPTURE: handler_addr = {zeros, mem_data_in[7:0]}; go to DONE.
- DONE: exc_done=1 for this cycle only, then go to IDLE.
- exc_req and addr_en are ignored in every state other than IDLE. Requests are not queued.
- Latency: exc_req accepted at edge N gives exc_done high in cycle N+3+MEM_LAT.
- busy is high from VEC_ADDR through DONE inclusive.
- misaligned is recomputed every cycle from the next addr_out value and word_access. It is also evaluated for vector addresses.
- addr_out is never driven combinationally from inputs. There is no latch inference; every register is assigned in clocked logic only.

Decomposition:
- Shared package cpu_mem_pkg holds:
  - the FSM state enum: IDLE, VEC_ADDR, WAIT, CAPTURE, DONE;
  - VEC_BASE_DEFAULT = 253;
  - named exception codes: EXC_OPCODE = 0, EXC_OVERFLOW = 1, EXC_DIV0 = 2.
- One sub-module, addr_src_mux: a parametrised combinational N_SRC:1 selector with a hold-on-invalid-select output flag. The FSM and registers stay in the top level.

Test Plan:
- Normal selection (DATA_W=32, N_SRC=3, MEM_LAT=1): in_src = {0x300, 0x200, 0x100}.
  - sel=1, addr_en=1 -> addr_out=0x200 after one edge.
  - sel=3 -> addr_out stays 0x200.
  - addr_en=0 with sel=2 -> addr_out holds.
- Exception path: exc_req pulse with exc_code=1 at edge N.
  - addr_out=254 in VEC_ADDR.
  - mem_data_in=0x0000_00A7 in CAPTURE -> handler_addr=0xA7.
  - exc_done high exactly in cycle N+4, low after.
  - busy high for 4 cycles.
- Bad code: exc_code=3 -> exc_bad=1 and addr_out=253.
  - A following good request with code 2 -> exc_bad=0 and addr_out=255.
- Priority and ignore: exc_req and addr_en in the same IDLE cycle -> FSM entered, addr_out not loaded from the source.
  - A second exc_req during WAIT -> ignored; exactly one exc_done pulse.
- Latency parameter (MEM_LAT=3): exc_done in cycle N+6.
  - Assert reset in WAIT -> all outputs 0 immediately; FSM in IDLE; no exc_done.
- Alignment: word_access=1 and load 0x102 -> misaligned=1.
  - Load 0x104 -> misaligned=0.
  - word_access=0 with 0x103 -> misaligned=0.
